// File: rtl/i2c_responder_regs.sv
// 7-bit-address I2C target with a byte register file, auto-incrementing pointer,
// a host-side write observation port and a registered side read port.
module i2c_responder_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         REG_DEPTH  = 16,
    parameter int         FILTER_LEN = 3,
    localparam int        AW         = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i2c_scl_i,
    input  logic          i2c_sda_i,
    output logic          i2c_sda_o,
    output logic          i2c_sda_t,
    output logic          busy,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] ST_WR_PTR   = 4'd3;
    localparam logic [3:0] ST_WRITE    = 4'd4;
    localparam logic [3:0] ST_DATA_ACK = 4'd5;
    localparam logic [3:0] ST_READ     = 4'd6;
    localparam logic [3:0] ST_READ_ACK = 4'd7;
    localparam logic [3:0] ST_IGNORE   = 4'd8;

    // Index 1 = SCL, index 0 = SDA. Idle bus level is high, so everything resets to 1.
    logic [1:0] pin_in;
    logic [1:0] line_f;

    assign pin_in = {i2c_scl_i, i2c_sda_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_in
            logic [1:0]            sync_reg;
            logic [FILTER_LEN-1:0] hist_reg;
            logic                  level_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync_reg  <= '1;
                    hist_reg  <= '1;
                    level_reg <= 1'b1;
                end else begin
                    sync_reg <= {sync_reg[0], pin_in[gi]};
                    hist_reg <= (hist_reg << 1) | FILTER_LEN'(sync_reg[1]);
                    if (&hist_reg) begin
                        level_reg <= 1'b1;
                    end else if (~|hist_reg) begin
                        level_reg <= 1'b0;
                    end
                end
            end

            assign line_f[gi] = level_reg;
        end
    endgenerate

    logic scl_f, sda_f, scl_q_reg, sda_q_reg;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_f     = line_f[1];
    assign sda_f     = line_f[0];
    assign scl_rise  = scl_f & ~scl_q_reg;
    assign scl_fall  = ~scl_f & scl_q_reg;
    assign start_det = scl_f & scl_q_reg & sda_q_reg & ~sda_f;
    assign stop_det  = scl_f & scl_q_reg & ~sda_q_reg & sda_f;

    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_q_reg <= 1'b1;
            sda_q_reg <= 1'b1;
        end else begin
            scl_q_reg <= scl_f;
            sda_q_reg <= sda_f;
        end
    end

    logic [7:0]    regs [REG_DEPTH];
    logic [3:0]    state_reg, state_next;
    logic [3:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    rx_reg, rx_next;
    logic [7:0]    tx_reg, tx_next;
    logic [AW-1:0] ptr_reg, ptr_next;
    logic [AW-1:0] ptr_inc;
    logic          sda_reg, sda_next;
    logic          busy_reg, busy_next;
    logic          rw_reg, rw_next;
    logic          ack_phase_reg, ack_phase_next;
    logic          master_ack_reg, master_ack_next;
    logic          wr_valid_reg, wr_valid_next;
    logic [AW-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]    wr_data_reg, wr_data_next;
    logic [7:0]    rx_byte;
    logic          reg_we;

    assign rx_byte = {rx_reg[6:0], sda_f};
    assign ptr_inc = ptr_reg + AW'(1);

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        rx_next         = rx_reg;
        tx_next         = tx_reg;
        ptr_next        = ptr_reg;
        sda_next        = sda_reg;
        busy_next       = busy_reg;
        rw_next         = rw_reg;
        ack_phase_next  = ack_phase_reg;
        master_ack_next = master_ack_reg;
        wr_valid_next   = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;
        reg_we          = 1'b0;

        // Bus conditions override whatever byte is in flight; a partial byte is simply dropped.
        if (stop_det) begin
            state_next     = ST_IDLE;
            sda_next       = 1'b1;
            busy_next      = 1'b0;
            ack_phase_next = 1'b0;
        end else if (start_det) begin
            state_next     = ST_ADDR;
            bit_cnt_next   = 4'd0;
            sda_next       = 1'b1;
            ack_phase_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    sda_next = 1'b1;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        rx_next      = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            ack_phase_next = 1'b0;
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_next = ST_ADDR_ACK;
                                busy_next  = 1'b1;
                                rw_next    = rx_byte[0];
                            end else begin
                                state_next = ST_IGNORE;
                                busy_next  = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // First fall ends the 8th bit (start ACK), second fall ends the ACK bit.
                    if (scl_fall) begin
                        if (!ack_phase_reg) begin
                            ack_phase_next = 1'b1;
                            sda_next       = 1'b0;
                        end else begin
                            ack_phase_next = 1'b0;
                            bit_cnt_next   = 4'd0;
                            if (rw_reg) begin
                                sda_next   = regs[ptr_reg][7];
                                tx_next    = {regs[ptr_reg][6:0], 1'b1};
                                state_next = ST_READ;
                            end else begin
                                sda_next   = 1'b1;
                                state_next = ST_WR_PTR;
                            end
                        end
                    end
                end
                ST_WR_PTR, ST_WRITE: begin
                    if (scl_rise) begin
                        rx_next      = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            if (state_reg == ST_WR_PTR) begin
                                ptr_next = rx_byte[AW-1:0];
                            end else begin
                                reg_we        = 1'b1;
                                wr_valid_next = 1'b1;
                                wr_addr_next  = ptr_reg;
                                wr_data_next  = rx_byte;
                                ptr_next      = ptr_inc;
                            end
                            ack_phase_next = 1'b0;
                            state_next     = ST_DATA_ACK;
                        end
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_reg) begin
                            ack_phase_next = 1'b1;
                            sda_next       = 1'b0;
                        end else begin
                            ack_phase_next = 1'b0;
                            sda_next       = 1'b1;
                            bit_cnt_next   = 4'd0;
                            state_next     = ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_next        = 1'b1;
                            master_ack_next = 1'b0;
                            state_next      = ST_READ_ACK;
                        end else begin
                            sda_next = tx_reg[7];
                            tx_next  = {tx_reg[6:0], 1'b1};
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        master_ack_next = ~sda_f;
                    end else if (scl_fall) begin
                        ptr_next     = ptr_inc;
                        bit_cnt_next = 4'd0;
                        if (master_ack_reg) begin
                            sda_next   = regs[ptr_inc][7];
                            tx_next    = {regs[ptr_inc][6:0], 1'b1};
                            state_next = ST_READ;
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
                ST_IGNORE: begin
                    sda_next = 1'b1;
                end
                default: begin
                    state_next = ST_IDLE;
                    sda_next   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 4'd0;
            rx_reg         <= 8'd0;
            tx_reg         <= 8'hFF;
            ptr_reg        <= '0;
            sda_reg        <= 1'b1;
            busy_reg       <= 1'b0;
            rw_reg         <= 1'b0;
            ack_phase_reg  <= 1'b0;
            master_ack_reg <= 1'b0;
            wr_valid_reg   <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= 8'd0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            rx_reg         <= rx_next;
            tx_reg         <= tx_next;
            ptr_reg        <= ptr_next;
            sda_reg        <= sda_next;
            busy_reg       <= busy_next;
            rw_reg         <= rw_next;
            ack_phase_reg  <= ack_phase_next;
            master_ack_reg <= master_ack_next;
            wr_valid_reg   <= wr_valid_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
        end
    end

    // Register file must clear on reset, so it is built from flops rather than RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= 8'd0;
            end
        end else if (reg_we) begin
            regs[ptr_reg] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= 8'd0;
        end else begin
            rd_data <= regs[rd_addr];
        end
    end

    assign i2c_sda_o = sda_reg;
    assign i2c_sda_t = sda_reg;
    assign busy      = busy_reg;
    assign wr_valid  = wr_valid_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;

endmodule

// File: tb/tb_i2c_responder_regs.sv
// Directed bench for i2c_responder_regs: bit-banged I2C controller on a wired-AND
// SDA line, write log captured from the observation port.
module tb_i2c_responder_regs;

    localparam int Q = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_o, sda_t, busy, wr_valid;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic       sda_line;

    int n_cmp = 0;
    int n_bad = 0;
    int low_cnt = 0;
    int tie_err = 0;
    logic [11:0] wr_log[$];

    always #5 clk = ~clk;

    assign sda_line = m_sda & sda_o;

    i2c_responder_regs #(.DEV_ADDR(7'h50), .REG_DEPTH(16), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .i2c_scl_i (m_scl),
        .i2c_sda_i (sda_line),
        .i2c_sda_o (sda_o),
        .i2c_sda_t (sda_t),
        .busy      (busy),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always @(negedge clk) begin
        if (wr_valid) wr_log.push_back({wr_addr, wr_data});
        if (!sda_o) low_cnt++;
        if (sda_t !== sda_o) tie_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic put_bit(input logic b);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_clk(2 * Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        b = sda_line; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        acked = ~b;
        $display("txn: wrote 0x%02h ack=%0d", d, acked);
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~ack);
        $display("txn: read 0x%02h ack=%0d", d, ack);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] idx, input logic [7:0] exp);
        rd_addr = idx;
        wait_clk(1);
        check(tag, rd_data, exp);
    endtask

    task automatic log_check(input string tag, input int idx, input logic [11:0] exp);
        check(tag, (idx < wr_log.size()) ? wr_log[idx] : 12'hFFF, exp);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;

        rd_addr = 4'd0;
        wait_clk(4);
        check("rst_sda_o", sda_o, 1'b1);
        check("rst_sda_t", sda_t, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, 8'd0);
        check("rst_rd_data", rd_data, 8'd0);
        rst = 1'b1;
        wait_clk(4);

        // Basic write with pointer 3
        wr_log.delete();
        i2c_start();
        put_byte(8'hA0, ack); check("w1_addr_ack", ack, 1'b1);
        put_byte(8'h03, ack); check("w1_ptr_ack", ack, 1'b1);
        put_byte(8'h11, ack); check("w1_d0_ack", ack, 1'b1);
        put_byte(8'h22, ack); check("w1_d1_ack", ack, 1'b1);
        check("w1_busy", busy, 1'b1);
        i2c_stop();
        wait_clk(2);
        $display("txn: write ptr=3 data 11 22 stop");
        check("w1_busy_after", busy, 1'b0);
        check("w1_log_n", wr_log.size(), 2);
        log_check("w1_log0", 0, {4'd3, 8'h11});
        log_check("w1_log1", 1, {4'd4, 8'h22});
        rd_check("w1_rd4", 4'd4, 8'h22);
        rd_check("w1_rd3", 4'd3, 8'h11);

        // Marker at index 5 for the pointer-after-read check
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h05, ack);
        put_byte(8'h5A, ack); check("w2_d_ack", ack, 1'b1);
        i2c_stop();
        $display("txn: write ptr=5 data 5a stop");

        // Set pointer, repeated START, read two bytes
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h03, ack);
        i2c_start();
        put_byte(8'hA1, ack); check("r1_addr_ack", ack, 1'b1);
        get_byte(d, 1'b1);    check("r1_byte0", d, 8'h11);
        get_byte(d, 1'b0);    check("r1_byte1", d, 8'h22);
        i2c_stop();
        i2c_start();
        put_byte(8'hA1, ack);
        get_byte(d, 1'b0);    check("r2_ptr5", d, 8'h5A);
        i2c_stop();
        $display("txn: read sequence done");

        // Foreign address and general call are ignored
        wr_log.delete();
        low_cnt = 0;
        i2c_start();
        put_byte(8'hA2, ack); check("na_a2_ack", ack, 1'b0);
        put_byte(8'h01, ack); check("na_a2_data_ack", ack, 1'b0);
        check("na_a2_busy", busy, 1'b0);
        i2c_stop();
        i2c_start();
        put_byte(8'h00, ack); check("na_gc_ack", ack, 1'b0);
        put_byte(8'h44, ack);
        check("na_gc_busy", busy, 1'b0);
        i2c_stop();
        $display("txn: foreign address and general call");
        check("na_sda_low", low_cnt, 0);
        check("na_log_n", wr_log.size(), 0);

        // Pointer wrap and pointer-byte truncation
        wr_log.delete();
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h0F, ack);
        put_byte(8'h55, ack); check("wrap_d0_ack", ack, 1'b1);
        put_byte(8'h66, ack); check("wrap_d1_ack", ack, 1'b1);
        i2c_stop();
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h13, ack);
        put_byte(8'h77, ack);
        i2c_stop();
        $display("txn: wrap writes");
        check("wrap_log_n", wr_log.size(), 3);
        log_check("wrap_log0", 0, {4'd15, 8'h55});
        log_check("wrap_log1", 1, {4'd0, 8'h66});
        log_check("wrap_log2", 2, {4'd3, 8'h77});
        rd_check("wrap_rd15", 4'd15, 8'h55);
        rd_check("wrap_rd0", 4'd0, 8'h66);

        // Reset while the responder drives a 0 (regs[4] = 0x22, MSB 0)
        i2c_start();
        put_byte(8'hA1, ack); check("rr_addr_ack", ack, 1'b1);
        check("rr_drive_low", sda_o, 1'b0);
        rst = 1'b0;
        wait_clk(1);
        check("rr_released", sda_o, 1'b1);
        wait_clk(4);
        rst = 1'b1;
        wait_clk(2);
        rd_check("rr_rd4_clear", 4'd4, 8'h00);
        rd_check("rr_rd15_clear", 4'd15, 8'h00);
        i2c_stop();
        wr_log.delete();
        i2c_start();
        put_byte(8'hA0, ack); check("rr_w_addr_ack", ack, 1'b1);
        put_byte(8'h02, ack); check("rr_w_ptr_ack", ack, 1'b1);
        put_byte(8'h9C, ack); check("rr_w_d_ack", ack, 1'b1);
        i2c_stop();
        $display("txn: write after reset");
        log_check("rr_log0", 0, {4'd2, 8'h9C});
        rd_check("rr_rd2", 4'd2, 8'h9C);

        // Aborted partial bytes: STOP then repeated START after 4 data bits
        wr_log.delete();
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h01, ack);
        for (int i = 0; i < 4; i++) put_bit(i[0]);
        i2c_stop();
        wait_clk(2);
        check("ab_stop_log_n", wr_log.size(), 0);
        check("ab_stop_busy", busy, 1'b0);
        i2c_start();
        put_byte(8'hA0, ack);
        put_byte(8'h01, ack);
        for (int i = 0; i < 4; i++) put_bit(~i[0]);
        i2c_start();
        put_byte(8'hA0, ack); check("ab_rs_addr_ack", ack, 1'b1);
        put_byte(8'h07, ack);
        put_byte(8'hE1, ack); check("ab_rs_d_ack", ack, 1'b1);
        i2c_stop();
        $display("txn: aborted partial bytes");
        check("ab_log_n", wr_log.size(), 1);
        log_check("ab_log0", 0, {4'd7, 8'hE1});
        rd_check("ab_rd1", 4'd1, 8'h00);
        check("sda_t_tie", tie_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
